// File: rtl/commit_unit_mw.sv
//-----------------------------------------------------------------------------
// commit_unit_mw
//
// Multi-wide, in-order retirement unit. Each cycle it looks at the oldest
// COMMIT_WIDTH reorder-buffer head entries and retires the longest legal
// in-order prefix. Retired results are written into the architectural
// register file, one store per cycle is released to the store buffer,
// mispredicts and exceptions raise a registered redirect/flush, and a
// 64-bit retired-instruction counter is kept.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   rob_valid           per-lane head entry valid and complete (lane 0 oldest)
//   rob_result          per-lane result value
//   rob_dest_reg        per-lane destination register
//   rob_instr_type      per-lane instruction class (ITYPE_* codes below)
//   rob_pc              per-lane instruction PC
//   rob_exception       per-lane exception flag
//   rob_mispredict      per-lane branch/jump mispredict flag
//   rob_target          per-lane corrected target for a mispredict
//   rob_retire_cnt      number of head entries freed this cycle (combinational)
//   sb_commit_valid     release oldest store this cycle (combinational)
//   sb_commit_ready     store buffer can accept a release
//   reg_write_en/addr/data  registered per-lane writeback strobe/address/data
//   flush_valid/flush_pc    registered one-cycle redirect pulse and target
//   exc_valid/exc_pc        registered one-cycle trap pulse and faulting PC
//   instret             retired-instruction counter
//   debug_reg_file      architectural register file readout
//-----------------------------------------------------------------------------

`ifndef ITYPE_ALU
`define ITYPE_ALU     4'd0
`define ITYPE_ALU_IMM 4'd1
`define ITYPE_LOAD    4'd2
`define ITYPE_STORE   4'd3
`define ITYPE_BRANCH  4'd4
`define ITYPE_JAL     4'd5
`define ITYPE_JALR    4'd6
`endif

module commit_unit_mw #(
   parameter int              XLEN         = 32,
   parameter int              NUM_INT_REGS = 32,
   parameter int              COMMIT_WIDTH = 2,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic [COMMIT_WIDTH-1:0]                  rob_valid,
   input  logic [COMMIT_WIDTH-1:0][XLEN-1:0]        rob_result,
   input  logic [COMMIT_WIDTH-1:0][4:0]             rob_dest_reg,
   input  logic [COMMIT_WIDTH-1:0][3:0]             rob_instr_type,
   input  logic [COMMIT_WIDTH-1:0][XLEN-1:0]        rob_pc,
   input  logic [COMMIT_WIDTH-1:0]                  rob_exception,
   input  logic [COMMIT_WIDTH-1:0]                  rob_mispredict,
   input  logic [COMMIT_WIDTH-1:0][XLEN-1:0]        rob_target,
   output logic [$clog2(COMMIT_WIDTH+1)-1:0]        rob_retire_cnt,
   output logic                                     sb_commit_valid,
   input  logic                                     sb_commit_ready,
   output logic [COMMIT_WIDTH-1:0]                  reg_write_en,
   output logic [COMMIT_WIDTH-1:0][4:0]             reg_write_addr,
   output logic [COMMIT_WIDTH-1:0][XLEN-1:0]        reg_write_data,
   output logic                                     flush_valid,
   output logic [XLEN-1:0]                          flush_pc,
   output logic                                     exc_valid,
   output logic [XLEN-1:0]                          exc_pc,
   output logic [63:0]                              instret,
   output logic [NUM_INT_REGS-1:0][XLEN-1:0]        debug_reg_file
);

   localparam int CNT_W = $clog2(COMMIT_WIDTH + 1);

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t state;

   logic [COMMIT_WIDTH-1:0]                 retire_mask;
   logic [COMMIT_WIDTH-1:0]                 write_req;
   logic [CNT_W-1:0]                        retire_cnt;
   logic                                    store_release;
   logic                                    flush_req;
   logic                                    exc_req;
   logic [XLEN-1:0]                         flush_target;
   logic [XLEN-1:0]                         exc_lane_pc;
   logic [NUM_INT_REGS-1:0][XLEN-1:0]       arch_regs;

   // Instruction classes that produce a register result.
   function automatic logic writes_rd(input logic [3:0] itype);
      logic result;
      result = 1'b0;
      case (itype)
         `ITYPE_ALU, `ITYPE_ALU_IMM, `ITYPE_LOAD, `ITYPE_JAL, `ITYPE_JALR: result = 1'b1;
         default: result = 1'b0;
      endcase
      return result;
   endfunction

   // Walk the head lanes oldest-first and find the retireable prefix. The
   // scan stops at the first lane that is not ready, faults, is a store that
   // cannot be released, or right after a mispredicted lane (which itself
   // retires). An exception lane is reported but not retired. Nothing is
   // retired while draining a flush or while reset is held, so the
   // combinational ROB/store-buffer handshakes stay quiet in those cycles.
   always_comb begin : retire_scan
      logic stop;
      logic store_taken;
      retire_mask   = '0;
      retire_cnt    = '0;
      store_release = 1'b0;
      flush_req     = 1'b0;
      exc_req       = 1'b0;
      flush_target  = '0;
      exc_lane_pc   = '0;
      stop          = (state != RUN) || !rst_n;
      store_taken   = 1'b0;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         if (!stop) begin
            if (!rob_valid[i]) begin
               stop = 1'b1;
            end else if (rob_exception[i]) begin
               exc_req      = 1'b1;
               exc_lane_pc  = rob_pc[i];
               flush_req    = 1'b1;
               flush_target = TRAP_VECTOR;
               stop         = 1'b1;
            end else if ((rob_instr_type[i] == `ITYPE_STORE) &&
                         (store_taken || !sb_commit_ready)) begin
               stop = 1'b1;
            end else begin
               retire_mask[i] = 1'b1;
               retire_cnt     = retire_cnt + CNT_W'(1);
               if (rob_instr_type[i] == `ITYPE_STORE) begin
                  store_taken   = 1'b1;
                  store_release = 1'b1;
               end
               if (rob_mispredict[i]) begin
                  flush_req    = 1'b1;
                  flush_target = rob_target[i];
                  stop         = 1'b1;
               end
            end
         end
      end
   end

   // A retired lane writes back only if its class produces a result and the
   // destination is not the hardwired-zero register.
   always_comb begin
      write_req = '0;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         write_req[i] = retire_mask[i] && writes_rd(rob_instr_type[i]) &&
                        (rob_dest_reg[i] != 5'd0);
      end
   end

   assign rob_retire_cnt  = retire_cnt;
   assign sb_commit_valid = store_release;

   // Control FSM plus all registered outputs. Any redirect sends the unit
   // into a single DRAIN cycle (during which the scan above retires nothing)
   // and it then resumes. Writeback address/data are zeroed for lanes that
   // do not write so idle lanes never show stale values. The redirect and
   // trap PCs hold their last value between pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= RUN;
         reg_write_en   <= '0;
         reg_write_addr <= '0;
         reg_write_data <= '0;
         flush_valid    <= 1'b0;
         flush_pc       <= '0;
         exc_valid      <= 1'b0;
         exc_pc         <= '0;
         instret        <= '0;
      end else begin
         case (state)
            RUN:     state <= flush_req ? DRAIN : RUN;
            DRAIN:   state <= RUN;
            default: state <= RUN;
         endcase
         reg_write_en <= write_req;
         for (int i = 0; i < COMMIT_WIDTH; i++) begin
            reg_write_addr[i] <= write_req[i] ? rob_dest_reg[i] : 5'd0;
            reg_write_data[i] <= write_req[i] ? rob_result[i] : '0;
         end
         flush_valid <= flush_req;
         if (flush_req) begin
            flush_pc <= flush_target;
         end
         exc_valid <= exc_req;
         if (exc_req) begin
            exc_pc <= exc_lane_pc;
         end
         instret <= instret + 64'(retire_cnt);
      end
   end

   // Architectural register file. Lanes are applied oldest to youngest so a
   // same-cycle write-after-write to one register leaves the younger value.
   // x0 is never written because write_req excludes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arch_regs <= '0;
      end else begin
         for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (write_req[i]) begin
               arch_regs[rob_dest_reg[i]] <= rob_result[i];
            end
         end
      end
   end

   assign debug_reg_file = arch_regs;

endmodule

// File: tb/tb_commit_unit_mw.sv
//-----------------------------------------------------------------------------
// tb_commit_unit_mw
//
// Self-checking bench for commit_unit_mw (2-wide, 32-bit). Directed steps
// cover reset, dual ALU retire, same-destination writes, x0, store pairing,
// store back-pressure, mispredict, exception, exception-before-mispredict and
// reset during a drain; a randomized phase then exercises mixed traffic.
// A behavioural model computes expectations from the retirement rules.
//-----------------------------------------------------------------------------
module tb_commit_unit_mw;

   localparam int              XLEN  = 32;
   localparam int              NREGS = 32;
   localparam int              W     = 2;
   localparam int              CW    = $clog2(W + 1);
   localparam logic [XLEN-1:0] TRAP  = 32'h0000_0100;

   localparam logic [3:0] T_ALU     = 4'd0;
   localparam logic [3:0] T_ALU_IMM = 4'd1;
   localparam logic [3:0] T_LOAD    = 4'd2;
   localparam logic [3:0] T_STORE   = 4'd3;
   localparam logic [3:0] T_BRANCH  = 4'd4;
   localparam logic [3:0] T_JAL     = 4'd5;
   localparam logic [3:0] T_JALR    = 4'd6;

   logic                          clk;
   logic                          rst_n;
   logic [W-1:0]                  rob_valid;
   logic [W-1:0][XLEN-1:0]        rob_result;
   logic [W-1:0][4:0]             rob_dest_reg;
   logic [W-1:0][3:0]             rob_instr_type;
   logic [W-1:0][XLEN-1:0]        rob_pc;
   logic [W-1:0]                  rob_exception;
   logic [W-1:0]                  rob_mispredict;
   logic [W-1:0][XLEN-1:0]        rob_target;
   logic [CW-1:0]                 rob_retire_cnt;
   logic                          sb_commit_valid;
   logic                          sb_commit_ready;
   logic [W-1:0]                  reg_write_en;
   logic [W-1:0][4:0]             reg_write_addr;
   logic [W-1:0][XLEN-1:0]        reg_write_data;
   logic                          flush_valid;
   logic [XLEN-1:0]               flush_pc;
   logic                          exc_valid;
   logic [XLEN-1:0]               exc_pc;
   logic [63:0]                   instret;
   logic [NREGS-1:0][XLEN-1:0]    debug_reg_file;

   int checks;
   int failures;

   // Model architectural state
   logic [NREGS-1:0][XLEN-1:0]    m_regs;
   logic [63:0]                   m_instret;
   bit                            m_draining;
   logic [W-1:0]                  m_we;
   logic [W-1:0][4:0]             m_waddr;
   logic [W-1:0][XLEN-1:0]        m_wdata;
   logic                          m_flush_valid;
   logic [XLEN-1:0]               m_flush_pc;
   logic                          m_exc_valid;
   logic [XLEN-1:0]               m_exc_pc;

   // Model view of the current cycle's retirement decision
   int                            mc_cnt;
   logic                          mc_sbv;
   logic [W-1:0]                  mc_mask;
   logic                          mc_flush;
   logic [XLEN-1:0]               mc_flush_pc;
   logic                          mc_exc;
   logic [XLEN-1:0]               mc_exc_pc;

   commit_unit_mw #(
      .XLEN(XLEN),
      .NUM_INT_REGS(NREGS),
      .COMMIT_WIDTH(W),
      .TRAP_VECTOR(TRAP)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .rob_valid(rob_valid),
      .rob_result(rob_result),
      .rob_dest_reg(rob_dest_reg),
      .rob_instr_type(rob_instr_type),
      .rob_pc(rob_pc),
      .rob_exception(rob_exception),
      .rob_mispredict(rob_mispredict),
      .rob_target(rob_target),
      .rob_retire_cnt(rob_retire_cnt),
      .sb_commit_valid(sb_commit_valid),
      .sb_commit_ready(sb_commit_ready),
      .reg_write_en(reg_write_en),
      .reg_write_addr(reg_write_addr),
      .reg_write_data(reg_write_data),
      .flush_valid(flush_valid),
      .flush_pc(flush_pc),
      .exc_valid(exc_valid),
      .exc_pc(exc_pc),
      .instret(instret),
      .debug_reg_file(debug_reg_file)
   );

   // 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts, and reports on mismatch.
   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare every DUT output against the model.
   task automatic checkOutput();
      checkVal("retire_cnt", 64'(rob_retire_cnt), 64'(mc_cnt));
      checkVal("sb_commit_valid", 64'(sb_commit_valid), 64'(mc_sbv));
      checkVal("reg_write_en", 64'(reg_write_en), 64'(m_we));
      checkVal("reg_write_addr", 64'(reg_write_addr), 64'(m_waddr));
      checkVal("reg_write_data", 64'(reg_write_data), 64'(m_wdata));
      checkVal("flush_valid", 64'(flush_valid), 64'(m_flush_valid));
      checkVal("flush_pc", 64'(flush_pc), 64'(m_flush_pc));
      checkVal("exc_valid", 64'(exc_valid), 64'(m_exc_valid));
      checkVal("exc_pc", 64'(exc_pc), 64'(m_exc_pc));
      checkVal("instret", instret, m_instret);
      checks++;
      assert (debug_reg_file === m_regs) else begin
         failures++;
         for (int r = 0; r < NREGS; r++) begin
            if (debug_reg_file[r] !== m_regs[r]) begin
               $error("[TB] FAIL regfile x%0d observed=%0h expected=%0h", r, debug_reg_file[r], m_regs[r]);
               break;
            end
         end
      end
   endtask

   task automatic applyStimulus(input int lane, input logic v, input logic [3:0] t,
                                input logic [4:0] d, input logic [XLEN-1:0] res,
                                input logic [XLEN-1:0] pc, input logic e, input logic mp,
                                input logic [XLEN-1:0] tgt);
      rob_valid[lane]      = v;
      rob_instr_type[lane] = t;
      rob_dest_reg[lane]   = d;
      rob_result[lane]     = res;
      rob_pc[lane]         = pc;
      rob_exception[lane]  = e;
      rob_mispredict[lane] = mp;
      rob_target[lane]     = tgt;
   endtask

   task automatic clearLanes();
      for (int i = 0; i < W; i++) applyStimulus(i, 1'b0, T_ALU, 5'd0, '0, '0, 1'b0, 1'b0, '0);
   endtask

   task automatic randomLane(input int lane);
      logic [3:0] t;
      logic       mp;
      t  = 4'($urandom_range(0, 6));
      mp = ((t == T_BRANCH) || (t == T_JAL) || (t == T_JALR)) && ($urandom_range(0, 3) == 0);
      applyStimulus(lane, $urandom_range(0, 9) != 0, t, 5'($urandom_range(0, 7)),
                    $urandom, $urandom, $urandom_range(0, 11) == 0, mp, $urandom);
   endtask

   task automatic modelReset();
      m_regs        = '0;
      m_instret     = '0;
      m_draining    = 1'b0;
      m_we          = '0;
      m_waddr       = '0;
      m_wdata       = '0;
      m_flush_valid = 1'b0;
      m_flush_pc    = '0;
      m_exc_valid   = 1'b0;
      m_exc_pc      = '0;
   endtask

   // Retirement rules: oldest-first prefix; stop at a not-ready lane, at an
   // exception (not retired, traps), at a store that is the second this cycle
   // or not accepted, and after a mispredicted lane (which does retire).
   task automatic modelComb();
      bit done;
      bit store_used;
      mc_cnt      = 0;
      mc_sbv      = 1'b0;
      mc_mask     = '0;
      mc_flush    = 1'b0;
      mc_flush_pc = '0;
      mc_exc      = 1'b0;
      mc_exc_pc   = '0;
      done        = m_draining || !rst_n;
      store_used  = 1'b0;
      for (int i = 0; i < W; i++) begin
         if (done) continue;
         if (!rob_valid[i]) begin
            done = 1'b1;
         end else if (rob_exception[i]) begin
            mc_exc = 1'b1; mc_exc_pc = rob_pc[i];
            mc_flush = 1'b1; mc_flush_pc = TRAP;
            done = 1'b1;
         end else if (rob_instr_type[i] == T_STORE && (store_used || !sb_commit_ready)) begin
            done = 1'b1;
         end else begin
            mc_mask[i] = 1'b1;
            mc_cnt++;
            if (rob_instr_type[i] == T_STORE) begin
               store_used = 1'b1;
               mc_sbv = 1'b1;
            end
            if (rob_mispredict[i]) begin
               mc_flush = 1'b1; mc_flush_pc = rob_target[i];
               done = 1'b1;
            end
         end
      end
   endtask

   // State update at the clock edge.
   task automatic modelClock();
      logic [3:0] t;
      if (!rst_n) begin
         modelReset();
         return;
      end
      for (int i = 0; i < W; i++) begin
         t = rob_instr_type[i];
         m_we[i] = mc_mask[i] && (rob_dest_reg[i] != 5'd0) &&
                   (t == T_ALU || t == T_ALU_IMM || t == T_LOAD || t == T_JAL || t == T_JALR);
         m_waddr[i] = m_we[i] ? rob_dest_reg[i] : 5'd0;
         m_wdata[i] = m_we[i] ? rob_result[i] : '0;
      end
      for (int i = 0; i < W; i++) begin
         if (m_we[i]) m_regs[rob_dest_reg[i]] = rob_result[i];
      end
      m_instret     = m_instret + 64'(mc_cnt);
      m_flush_valid = mc_flush;
      if (mc_flush) m_flush_pc = mc_flush_pc;
      m_exc_valid   = mc_exc;
      if (mc_exc) m_exc_pc = mc_exc_pc;
      m_draining    = mc_flush;
   endtask

   // One clock: settle, check against model, clock both, return at negedge.
   task automatic doCycle();
      #1;
      modelComb();
      checkOutput();
      @(posedge clk);
      modelClock();
      @(negedge clk);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b1;
      sb_commit_ready = 1'b1;
      clearLanes();
      modelReset();

      // Reset with both lanes presented as valid ALU ops
      applyStimulus(0, 1'b1, T_ALU, 5'd1, 32'h11, 32'h0, 1'b0, 1'b0, '0);
      applyStimulus(1, 1'b1, T_ALU, 5'd2, 32'h22, 32'h4, 1'b0, 1'b0, '0);
      #1 rst_n = 1'b0;
      @(negedge clk);
      #1 checkVal("reset_retire_cnt", 64'(rob_retire_cnt), 64'd0);
      doCycle();
      doCycle();
      rst_n = 1'b1;

      // Dual ALU
      applyStimulus(0, 1'b1, T_ALU, 5'd1, 32'd5, 32'h10, 1'b0, 1'b0, '0);
      applyStimulus(1, 1'b1, T_ALU, 5'd2, 32'd7, 32'h14, 1'b0, 1'b0, '0);
      #1 checkVal("dual_alu_cnt", 64'(rob_retire_cnt), 64'd2);
      doCycle();
      checkVal("dual_alu_we", 64'(reg_write_en), 64'd3);
      checkVal("dual_alu_x1", 64'(debug_reg_file[1]), 64'd5);
      checkVal("dual_alu_x2", 64'(debug_reg_file[2]), 64'd7);
      checkVal("dual_alu_instret", instret, 64'd2);

      // Same destination: younger lane wins
      applyStimulus(0, 1'b1, T_ALU, 5'd3, 32'd1, 32'h18, 1'b0, 1'b0, '0);
      applyStimulus(1, 1'b1, T_ALU_IMM, 5'd3, 32'd9, 32'h1c, 1'b0, 1'b0, '0);
      doCycle();
      checkVal("waw_x3", 64'(debug_reg_file[3]), 64'd9);
      checkVal("waw_both_we", 64'(reg_write_en), 64'd3);

      // x0 destination: no strobe, x0 stays zero
      clearLanes();
      applyStimulus(0, 1'b1, T_ALU, 5'd0, 32'd4, 32'h20, 1'b0, 1'b0, '0);
      doCycle();
      checkVal("x0_we", 64'(reg_write_en), 64'd0);
      checkVal("x0_value", 64'(debug_reg_file[0]), 64'd0);

      // Two stores: only one releases per cycle
      applyStimulus(0, 1'b1, T_STORE, 5'd4, 32'h0, 32'h24, 1'b0, 1'b0, '0);
      applyStimulus(1, 1'b1, T_STORE, 5'd5, 32'h0, 32'h28, 1'b0, 1'b0, '0);
      #1 checkVal("two_store_cnt", 64'(rob_retire_cnt), 64'd1);
      checkVal("two_store_sbv", 64'(sb_commit_valid), 64'd1);
      doCycle();
      applyStimulus(0, 1'b1, T_STORE, 5'd5, 32'h0, 32'h28, 1'b0, 1'b0, '0);
      applyStimulus(1, 1'b0, T_ALU, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, '0);
      #1 checkVal("second_store_cnt", 64'(rob_retire_cnt), 64'd1);
      doCycle();
      sb_commit_ready = 1'b0;
      applyStimulus(0, 1'b1, T_STORE, 5'd6, 32'h0, 32'h2c, 1'b0, 1'b0, '0);
      #1 checkVal("store_blocked_cnt", 64'(rob_retire_cnt), 64'd0);
      doCycle();
      sb_commit_ready = 1'b1;

      // Mispredicted JAL retires with its link write, younger lane is dropped
      applyStimulus(0, 1'b1, T_JAL, 5'd1, 32'h44, 32'h30, 1'b0, 1'b1, 32'h200);
      applyStimulus(1, 1'b1, T_ALU, 5'd7, 32'h77, 32'h34, 1'b0, 1'b0, '0);
      #1 checkVal("mp_cnt", 64'(rob_retire_cnt), 64'd1);
      doCycle();
      checkVal("mp_x1", 64'(debug_reg_file[1]), 64'h44);
      checkVal("mp_flush_valid", 64'(flush_valid), 64'd1);
      checkVal("mp_flush_pc", 64'(flush_pc), 64'h200);
      applyStimulus(0, 1'b1, T_ALU, 5'd7, 32'h77, 32'h200, 1'b0, 1'b0, '0);
      #1 checkVal("drain_cnt", 64'(rob_retire_cnt), 64'd0);
      doCycle();
      checkVal("after_drain_flush", 64'(flush_valid), 64'd0);

      // Exception in lane 1: lane 0 retires, lane 1 traps
      applyStimulus(0, 1'b1, T_ALU, 5'd6, 32'h66, 32'h7c, 1'b0, 1'b0, '0);
      applyStimulus(1, 1'b1, T_ALU, 5'd8, 32'h88, 32'h80, 1'b1, 1'b0, '0);
      #1 checkVal("exc_cnt", 64'(rob_retire_cnt), 64'd1);
      doCycle();
      checkVal("exc_valid", 64'(exc_valid), 64'd1);
      checkVal("exc_pc", 64'(exc_pc), 64'h80);
      checkVal("exc_flush_pc", 64'(flush_pc), 64'h100);
      clearLanes();
      doCycle();

      // Exception ahead of a mispredict wins
      applyStimulus(0, 1'b1, T_LOAD, 5'd9, 32'h99, 32'h90, 1'b1, 1'b0, '0);
      applyStimulus(1, 1'b1, T_JAL, 5'd1, 32'h94, 32'h94, 1'b0, 1'b1, 32'h300);
      #1 checkVal("exc_mp_cnt", 64'(rob_retire_cnt), 64'd0);
      doCycle();
      checkVal("exc_mp_flush_pc", 64'(flush_pc), 64'h100);
      checkVal("exc_mp_exc_pc", 64'(exc_pc), 64'h90);
      clearLanes();
      doCycle();

      // Reset asserted in the middle of a drain cycle
      applyStimulus(0, 1'b1, T_BRANCH, 5'd0, 32'h0, 32'h40, 1'b0, 1'b1, 32'h400);
      doCycle();
      rst_n = 1'b0;
      modelReset();
      #1 checkVal("rst_drain_flush", 64'(flush_valid), 64'd0);
      checkVal("rst_drain_instret", instret, 64'd0);
      doCycle();
      rst_n = 1'b1;
      clearLanes();
      doCycle();

      // Randomized mixed traffic
      for (int n = 0; n < 400; n++) begin
         sb_commit_ready = ($urandom_range(0, 3) != 0);
         for (int l = 0; l < W; l++) randomLane(l);
         doCycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
